// File: rtl/i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_pkg
// Description : Shared constants, state encoding and the word-select decode
//               helper for the I2S transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_tx_pkg;

    // Framing modes selected by ws_align
    localparam logic WS_STANDARD  = 1'b0;   // WS leads the MSB by one slot
    localparam logic WS_LEFT_JUST = 1'b1;   // WS edge aligned with the MSB

    // Transmitter state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Word-select level for a given slot of a 2*dw slot frame.
    // Standard framing moves both WS edges one slot earlier than the data,
    // so the right-channel window is [dw-1, 2*dw-2].
    function automatic logic ws_level(input int unsigned slot,
                                      input int unsigned dw,
                                      input logic        align);
        logic lvl;
        lvl = 1'b0;
        case (align)
            WS_STANDARD:  lvl = (slot >= dw - 1) && (slot <= 2 * dw - 2);
            WS_LEFT_JUST: lvl = (slot >= dw);
            default:      lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage : i2s_tx_pkg
`default_nettype wire

// File: rtl/i2s_tx_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_bclk_gen
// Description : Bit-clock divider and slot counter for the I2S transmitter.
//               Each slot lasts 2*CLK_DIV clk cycles; the bit clock is low for
//               the first half and high for the second half of every slot.
//               The strobes describe the position being entered on the next
//               rising clk edge so the caller can update registered outputs
//               on that same edge.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_ena             - run request; 0 holds counters at zero
//               i_running         - transmitter already in RUN state
//               o_bclk            - registered bit clock
//               o_slot_next       - slot index entered on the next edge
//               o_slot_start      - next edge begins a new slot
//               o_frame_load      - next edge begins slot 0 (frame load)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_bclk_gen #(
    parameter int unsigned DW      = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_ena,
    input  logic                        i_running,
    output logic                        o_bclk,
    output logic [$clog2(2*DW)-1:0]     o_slot_next,
    output logic                        o_slot_start,
    output logic                        o_frame_load
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV);
    localparam int unsigned SW = $clog2(2 * DW);

    localparam logic [CW-1:0] c_cnt_last  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] c_cnt_high  = CW'(CLK_DIV);
    localparam logic [SW-1:0] c_slot_last = SW'(2 * DW - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [SW-1:0] r_slot;
    logic          r_bclk;

    always_comb begin
        w_cnt_next   = '0;
        o_slot_next  = '0;
        o_slot_start = 1'b0;
        o_frame_load = 1'b0;
        if (i_ena) begin
            if (!i_running) begin
                // Leaving IDLE: the very next edge starts a fresh frame
                o_slot_start = 1'b1;
                o_frame_load = 1'b1;
            end else if (r_cnt == c_cnt_last) begin
                // Divider wrap is the bit-clock falling edge
                o_slot_start = 1'b1;
                if (r_slot == c_slot_last) begin
                    o_frame_load = 1'b1;
                end else begin
                    o_slot_next = r_slot + 1'b1;
                end
            end else begin
                w_cnt_next  = r_cnt + 1'b1;
                o_slot_next = r_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
            r_bclk <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_slot <= o_slot_next;
            r_bclk <= i_ena && (w_cnt_next >= c_cnt_high);
        end
    end

    assign o_bclk = r_bclk;

endmodule : i2s_bclk_gen
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : I2S bus master transmitter. Serialises stereo PCM pairs MSB
//               first onto i2s_clk / i2s_ws / i2s_dout, with standard I2S or
//               left-justified framing. A one-deep holding register decouples
//               the sample source; when it is empty at a frame boundary the
//               previous pair is repeated and underrun pulses.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               ena               - 1 transmit frames, 0 return to idle
//               ws_align          - 0 standard I2S, 1 left-justified
//               left_data         - left sample (DW bits)
//               right_data        - right sample (DW bits)
//               din_valid         - sample pair valid
//               din_ready         - holding register empty
//               i2s_clk           - bit clock
//               i2s_ws            - word select (0 left, 1 right)
//               i2s_dout          - serial data, changes on falling i2s_clk
//               frame_start       - 1-clk pulse as slot 0 begins
//               underrun          - 1-clk pulse when a frame repeats data
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int unsigned DW      = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          ws_align,
    input  logic [DW-1:0] left_data,
    input  logic [DW-1:0] right_data,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          i2s_clk,
    output logic          i2s_ws,
    output logic          i2s_dout,
    output logic          frame_start,
    output logic          underrun
);

    import i2s_tx_pkg::*;

    localparam int unsigned SW = $clog2(2 * DW);

    state_t          r_state;
    logic            w_slot_start;
    logic            w_frame_load;
    logic [SW-1:0]   w_slot_next;

    logic [DW-1:0]   r_hold_l;
    logic [DW-1:0]   r_hold_r;
    logic            r_hold_full;
    logic            w_hold_full_next;
    logic            r_din_ready;
    logic            w_accept;

    logic [2*DW-1:0] r_last;
    logic [2*DW-1:0] r_shift;
    logic [2*DW-1:0] w_frame_pair;

    logic            r_ws_align;
    logic            r_ws;
    logic            r_dout;
    logic            r_frame_start;
    logic            r_underrun;

    i2s_bclk_gen #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk          (clk),
        .rst          (rst),
        .i_ena        (ena),
        .i_running    (r_state == ST_RUN),
        .o_bclk       (i2s_clk),
        .o_slot_next  (w_slot_next),
        .o_slot_start (w_slot_start),
        .o_frame_load (w_frame_load)
    );

    // ------------------------------------------------------------------------
    // State: RUN follows ena one cycle later; any ena=0 cycle abandons the frame
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= ena ? ST_RUN : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Holding / last-pair registers and handshake.
    // A load in the same cycle as an accept sees the pre-accept (empty) state,
    // so the new pair waits for the following frame.
    // ------------------------------------------------------------------------
    assign w_accept     = din_valid & r_din_ready;
    assign w_frame_pair = r_hold_full ? {r_hold_l, r_hold_r} : r_last;

    always_comb begin
        w_hold_full_next = r_hold_full;
        if (w_frame_load && r_hold_full) begin
            w_hold_full_next = 1'b0;
        end
        if (w_accept) begin
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_din_ready <= 1'b1;
            r_last      <= '0;
        end else begin
            if (w_frame_load && r_hold_full) begin
                r_last <= {r_hold_l, r_hold_r};
            end
            if (w_accept) begin
                r_hold_l <= left_data;
                r_hold_r <= right_data;
            end
            r_hold_full <= w_hold_full_next;
            r_din_ready <= ~w_hold_full_next;
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser and word select. The shift register holds the bits still to
    // be sent; the bit for the slot being entered goes straight to r_dout.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_ws_align    <= WS_STANDARD;
            r_ws          <= 1'b0;
            r_dout        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_frame_load;
            r_underrun    <= w_frame_load & ~r_hold_full;
            if (!ena) begin
                r_ws   <= 1'b0;
                r_dout <= 1'b0;
            end else if (w_frame_load) begin
                // ws_align is captured only here and governs the whole frame
                r_ws_align <= ws_align;
                r_shift    <= {w_frame_pair[2*DW-2:0], 1'b0};
                r_dout     <= w_frame_pair[2*DW-1];
                r_ws       <= ws_level(32'd0, DW, ws_align);
            end else if (w_slot_start) begin
                r_shift <= {r_shift[2*DW-2:0], 1'b0};
                r_dout  <= r_shift[2*DW-1];
                r_ws    <= ws_level(32'(w_slot_next), DW, r_ws_align);
            end
        end
    end

    assign din_ready   = r_din_ready;
    assign i2s_ws      = r_ws;
    assign i2s_dout    = r_dout;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule : i2s_tx
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx
// Description : Self-checking bench for i2s_tx (DW=16, CLK_DIV=2). A
//               behavioural frame model predicts the handshake strobes and
//               pushes expected words to a scoreboard at each frame load; a
//               bench-side I2S receiver decodes the serial stream and pops it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;
    import i2s_tx_pkg::*;

    localparam int unsigned DW      = 16;
    localparam int unsigned CLK_DIV = 2;
    localparam int          FRAME   = 2 * DW * 2 * CLK_DIV;   // 128 clk

    logic          clk = 1'b0;
    logic          rst, ena, ws_align, din_valid;
    logic [DW-1:0] left_data, right_data;
    logic          din_ready, i2s_clk, i2s_ws, i2s_dout, frame_start, underrun;

    always #5 clk = ~clk;

    i2s_tx #(.DW(DW), .CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .ws_align    (ws_align),
        .left_data   (left_data),
        .right_data  (right_data),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .i2s_clk     (i2s_clk),
        .i2s_ws      (i2s_ws),
        .i2s_dout    (i2s_dout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          ch;
        logic [DW-1:0] w;
    } word_t;
    word_t exp_q[$];

    // ---------------- reference frame model (posedge) ----------------
    logic            m_run = 1'b0, m_full = 1'b0, m_acc = 1'b0;
    int              m_pos = 0;
    logic [DW-1:0]   m_hl = '0, m_hr = '0;
    logic [2*DW-1:0] m_last = '0;
    logic            e_fs = 1'b0, e_ur = 1'b0, e_rdy = 1'b1, e_bclk = 1'b0;

    // ---------------- bench I2S receiver state ----------------
    logic          rx_align = 1'b0, rx_start = 1'b0, rx_pend = 1'b0, rx_prev = 1'b0, rx_ch = 1'b0;
    int            rx_n = 0;
    logic [DW-1:0] rx_sh = '0;

    int n_fs = 0, n_ur = 0, n_words = 0;

    always @(posedge clk) begin : model
        logic acc;
        e_fs  = 1'b0;
        e_ur  = 1'b0;
        m_acc = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_full = 1'b0;
            m_last = '0;
            exp_q.delete();
        end else begin
            acc = din_valid && !m_full;
            if (!ena) begin
                m_run = 1'b0;
                exp_q.delete();
            end else if (!m_run || m_pos == FRAME - 1) begin
                if (!m_run) begin
                    // fresh run: arm the receiver for this framing mode
                    rx_align = ws_align;
                    rx_n     = 0;
                    rx_start = (ws_align == WS_STANDARD);
                    rx_pend  = 1'b0;
                    rx_prev  = (ws_align == WS_LEFT_JUST);
                end
                m_run = 1'b1;
                m_pos = 0;
                e_fs  = 1'b1;
                if (m_full) begin
                    exp_q.push_back('{ch: 1'b0, w: m_hl});
                    exp_q.push_back('{ch: 1'b1, w: m_hr});
                    m_last = {m_hl, m_hr};
                    m_full = 1'b0;
                end else begin
                    exp_q.push_back('{ch: 1'b0, w: m_last[2*DW-1:DW]});
                    exp_q.push_back('{ch: 1'b1, w: m_last[DW-1:0]});
                    e_ur = 1'b1;
                end
            end else begin
                m_pos++;
            end
            if (acc) begin
                m_hl   = left_data;
                m_hr   = right_data;
                m_full = 1'b1;
                m_acc  = 1'b1;
            end
        end
        e_rdy  = !m_full;
        e_bclk = m_run && ((m_pos % (2 * CLK_DIV)) >= CLK_DIV);
    end

    task automatic rx_emit();
        word_t e;
        n_words++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_word: actual=0x%0h required=none (queue empty, t=%0t)", {rx_ch, rx_sh}, $time);
        end else begin
            e = exp_q.pop_front();
            check("rx_word", {15'd0, rx_ch, rx_sh}, {15'd0, e});
        end
    endtask

    // One bit-clock rising edge as seen by an I2S slave receiver
    task automatic rx_bit(input logic ws, input logic d);
        if (rx_align) begin
            if (ws != rx_prev) begin
                rx_sh = {{(DW-1){1'b0}}, d};
                rx_n  = 1;
                rx_ch = ws;
            end else if (rx_n > 0 && rx_n < DW) begin
                rx_sh = {rx_sh[DW-2:0], d};
                rx_n++;
            end
        end else begin
            if (rx_n > 0 && rx_n < DW) begin
                rx_sh = {rx_sh[DW-2:0], d};
                rx_n++;
            end else if (rx_start) begin
                rx_sh    = {{(DW-1){1'b0}}, d};
                rx_n     = 1;
                rx_ch    = rx_pend;
                rx_start = 1'b0;
            end
            if (ws != rx_prev) begin
                rx_start = 1'b1;
                rx_pend  = ws;
            end
        end
        rx_prev = ws;
        if (rx_n == DW) begin
            rx_n = 0;
            rx_emit();
        end
    endtask

    // ---------------- monitor (negedge) ----------------
    int   cyc = 0, ws_fall_cyc = -100, fs_in_run = 0;
    logic prev_ws = 1'b0, prev_bclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        check("frame_start", frame_start, e_fs);
        check("underrun",    underrun,    e_ur);
        check("din_ready",   din_ready,   e_rdy);
        check("i2s_clk",     i2s_clk,     e_bclk);
        if (!m_run) begin
            check("idle_ws",   i2s_ws,   1'b0);
            check("idle_dout", i2s_dout, 1'b0);
            fs_in_run = 0;
        end
        if (prev_ws && !i2s_ws) ws_fall_cyc = cyc;
        if (frame_start) begin
            if (fs_in_run > 0)
                check("ws_lead", cyc - ws_fall_cyc, rx_align ? 0 : 2 * CLK_DIV);
            fs_in_run++;
            n_fs++;
        end
        if (underrun) n_ur++;
        if (i2s_clk && !prev_bclk) rx_bit(i2s_ws, i2s_dout);
        prev_ws   = i2s_ws;
        prev_bclk = i2s_clk;
    end

    // Inputs change 1 ns after the falling edge, clear of both sampling points
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [DW-1:0] l, input logic [DW-1:0] r);
        left_data  = l;
        right_data = r;
        din_valid  = 1'b1;
        tick(1);
        din_valid  = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          align;
        int            frames;
        int            exp_ur;
    } vec_t;

    vec_t vecs[5];
    int   fs0, ur0, w0, pair_i;

    initial begin
        vecs[0] = '{16'hA5C3, 16'h1234, WS_STANDARD,  2, 1};
        vecs[1] = '{16'hA5C3, 16'h1234, WS_LEFT_JUST, 2, 1};
        vecs[2] = '{16'h8001, 16'h7FFE, WS_STANDARD,  3, 2};
        vecs[3] = '{16'h0000, 16'hFFFF, WS_LEFT_JUST, 1, 0};
        vecs[4] = '{16'hFFFF, 16'h0001, WS_STANDARD,  1, 0};

        rst = 1'b1; ena = 1'b0; ws_align = 1'b0; din_valid = 1'b0;
        left_data = '0; right_data = '0;
        tick(3);
        check("rst_din_ready",   din_ready,   1'b1);
        check("rst_i2s_clk",     i2s_clk,     1'b0);
        check("rst_i2s_ws",      i2s_ws,      1'b0);
        check("rst_i2s_dout",    i2s_dout,    1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_underrun",    underrun,    1'b0);
        rst = 1'b0;
        tick(2);

        // ---- table: one pair pushed while idle, then N frames ----
        for (int i = 0; i < 5; i++) begin
            ws_align = vecs[i].align;
            push_idle(vecs[i].l, vecs[i].r);
            fs0 = n_fs; ur0 = n_ur; w0 = n_words;
            ena = 1'b1;
            tick(FRAME * vecs[i].frames);
            ena = 1'b0;
            tick(4);
            check("vec_frames",    n_fs - fs0,    vecs[i].frames);
            check("vec_underruns", n_ur - ur0,    vecs[i].exp_ur);
            check("vec_words",     n_words - w0,  2 * vecs[i].frames);
        end

        // ---- source holds din_valid with incrementing pairs ----
        ws_align   = WS_STANDARD;
        pair_i     = 0;
        left_data  = 16'h1000;
        right_data = 16'h2000;
        din_valid  = 1'b1;
        tick(1);
        fs0 = n_fs; ur0 = n_ur; w0 = n_words;
        ena = 1'b1;
        for (int c = 0; c < FRAME * 5; c++) begin
            if (m_acc) begin
                pair_i++;
                if (pair_i < 5) begin
                    left_data  = 16'h1000 + 16'(pair_i);
                    right_data = 16'h2000 + 16'(pair_i);
                end else begin
                    din_valid = 1'b0;
                end
            end
            tick(1);
        end
        ena = 1'b0;
        din_valid = 1'b0;
        tick(4);
        check("stream_frames",    n_fs - fs0,   5);
        check("stream_underruns", n_ur - ur0,   0);
        check("stream_words",     n_words - w0, 10);

        // ---- push on the exact frame-load cycle with holding empty ----
        fs0 = n_fs; ur0 = n_ur; w0 = n_words;
        left_data  = 16'hCAFE;
        right_data = 16'hBEEF;
        din_valid  = 1'b1;
        ena        = 1'b1;
        tick(1);
        din_valid  = 1'b0;
        check("loadpush_underrun", underrun,  1'b1);
        check("loadpush_ready",    din_ready, 1'b0);
        tick(2 * FRAME - 1);
        ena = 1'b0;
        tick(4);
        check("loadpush_underruns", n_ur - ur0,   1);
        check("loadpush_words",     n_words - w0, 4);

        // ---- reset asserted during slot 10 ----
        push_idle(16'h1111, 16'h2222);
        ena = 1'b1;
        tick(1);
        push_idle(16'h3333, 16'h4444);
        tick(39);
        check("rst_mid_ready_before", din_ready, 1'b0);
        rst = 1'b1;
        tick(1);
        check("rst_mid_i2s_clk",     i2s_clk,     1'b0);
        check("rst_mid_i2s_ws",      i2s_ws,      1'b0);
        check("rst_mid_i2s_dout",    i2s_dout,    1'b0);
        check("rst_mid_frame_start", frame_start, 1'b0);
        check("rst_mid_underrun",    underrun,    1'b0);
        check("rst_mid_din_ready",   din_ready,   1'b1);
        rst = 1'b0;
        w0  = n_words;
        tick(1);
        check("rst_restart_fs", frame_start, 1'b1);
        check("rst_restart_ur", underrun,    1'b1);
        tick(FRAME - 1);
        ena = 1'b0;
        tick(4);
        check("rst_restart_words", n_words - w0, 2);

        // ---- ena dropped mid-frame ----
        push_idle(16'h5A5A, 16'hC3C3);
        ena = 1'b1;
        tick(41);
        ena = 1'b0;
        tick(1);
        check("ena_low_i2s_clk", i2s_clk, 1'b0);
        tick(5);
        check("ena_low_held_clk", i2s_clk,     1'b0);
        check("ena_low_held_fs",  frame_start, 1'b0);
        w0  = n_words;
        ena = 1'b1;
        tick(1);
        check("ena_restart_fs",  frame_start, 1'b1);
        check("ena_restart_clk", i2s_clk,     1'b0);
        tick(2);
        check("ena_restart_clk_hi", i2s_clk, 1'b1);
        tick(FRAME - 3);
        ena = 1'b0;
        tick(4);
        check("ena_restart_words", n_words - w0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_i2s_tx
`default_nettype wire
